// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scanner: digit count, the active-low
// hex glyph table (bits 6:0 = g..a) and the all-off pattern.
package seg7_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Entry n is the glyph for nibble n, '0' lights the segment.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seven_seg_scan_if.sv
// Display-side bundle of the seven-segment scanner: data/control inputs from
// the producer and the multiplexed anode/segment drive back out.
interface seven_seg_scan_if;

    logic        EN;
    logic [31:0] Disp_num;
    logic [7:0]  point_in;
    logic [7:0]  blink_in;
    logic [7:0]  AN;
    logic [7:0]  SEGMENT;
    logic        frame_done;

    modport master (
        output EN, Disp_num, point_in, blink_in,
        input  AN, SEGMENT, frame_done
    );

    modport slave (
        input  EN, Disp_num, point_in, blink_in,
        output AN, SEGMENT, frame_done
    );

endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low seven-segment glyph (g..a).
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nib];

endmodule

// File: rtl/seven_seg_scan.sv
// Eight-digit multiplexed seven-segment scanner with frame-aligned input snapshots.
// Optional blink support is compiled in when SEG_BLINK_EN is defined.
module seven_seg_scan
    import seg7_pkg::*;
#(
    parameter int SCAN_PERIOD  = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic             clk,
    input  logic             rst,
    seven_seg_scan_if.slave  bus
);

    localparam int CW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             fd_q, fd_d;
    logic [31:0]      num_q, num_d;
    logic [7:0]       pt_q, pt_d;
    logic [7:0]       an_q, an_d;
    logic [7:0]       seg_q, seg_d;
    logic             tick, frame_end, blank;
    logic [3:0]       nib;
    logic [6:0]       glyph;

    assign tick      = (cnt_q == CW'(SCAN_PERIOD - 1));
    assign frame_end = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));
    assign nib       = num_q[{idx_q, 2'b00} +: 4];

    seg7_hex_decode u_dec (.nib(nib), .seg(glyph));

`ifdef SEG_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          phase_q, phase_d;
    logic [7:0]    blk_q, blk_d;

    always_comb begin
        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        blk_d   = blk_q;
        if (frame_end) begin
            blk_d = bus.blink_in;
            if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt_q  <= '0;
            phase_q <= 1'b0;
            blk_q   <= '0;
        end else begin
            fcnt_q  <= fcnt_d;
            phase_q <= phase_d;
            blk_q   <= blk_d;
        end
    end

    assign blank = phase_q & blk_q[idx_q];
`else
    logic unused_blink;
    assign unused_blink = ^bus.blink_in;
    assign blank        = 1'b0;
`endif

    // Outputs follow idx_q, so a new digit appears one cycle after its tick.
    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        idx_d = tick ? idx_q + 1'b1 : idx_q;
        fd_d  = frame_end;
        num_d = frame_end ? bus.Disp_num : num_q;
        pt_d  = frame_end ? bus.point_in : pt_q;
        an_d  = bus.EN ? ~(8'b1 << idx_q) : SEG_BLANK;
        seg_d = (!bus.EN || blank) ? SEG_BLANK : {~pt_q[idx_q], glyph};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
            fd_q  <= 1'b0;
            num_q <= '0;
            pt_q  <= '0;
            an_q  <= SEG_BLANK;
            seg_q <= SEG_BLANK;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            fd_q  <= fd_d;
            num_q <= num_d;
            pt_q  <= pt_d;
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign bus.AN         = an_q;
    assign bus.SEGMENT    = seg_q;
    assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan: expected per-cycle display words are queued
// per frame and popped against the DUT on each falling edge.
module tb_seven_seg_scan;

    localparam int SP = 4;
    localparam int BF = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seven_seg_scan_if bus();

    seven_seg_scan #(.SCAN_PERIOD(SP), .BLINK_FRAMES(BF)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [7:0] an;
        logic [7:0] seg;
        logic       fd;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic [31:0] in_num, snap_num;
    logic [7:0]  in_pt, snap_pt, in_blk, snap_blk;
    bit          phase;

    // Independent glyph reference, written active-high (gfedcba) then inverted.
    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] h;
        case (n)
            4'h0: h = 7'h3F; 4'h1: h = 7'h06; 4'h2: h = 7'h5B; 4'h3: h = 7'h4F;
            4'h4: h = 7'h66; 4'h5: h = 7'h6D; 4'h6: h = 7'h7D; 4'h7: h = 7'h07;
            4'h8: h = 7'h7F; 4'h9: h = 7'h6F; 4'hA: h = 7'h77; 4'hB: h = 7'h7C;
            4'hC: h = 7'h39; 4'hD: h = 7'h5E; 4'hE: h = 7'h79; default: h = 7'h71;
        endcase
        return ~h;
    endfunction

    task automatic drive();
        bus.Disp_num = in_num;
        bus.point_in = in_pt;
        bus.blink_in = in_blk;
    endtask

    task automatic chk(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc%0d: observed %h expected %h", tag, k, obs, exp);
        end
    endtask

    // Checks one 32-cycle frame starting right after a frame boundary (or reset release).
    task automatic frame(input string name, input bit en, input int chg_at,
                         input logic [31:0] nn, input logic [7:0] np, input logic [7:0] nb,
                         input int abort_at);
        exp_t       e;
        exp_t       got;
        int         d;
        bit         blank;
        logic [7:0] one;
        bus.EN = en;
        for (int k = 1; k <= 32; k++) begin
            d     = (k - 1) / 4;
            one   = 8'h01 << d;
            blank = 1'b0;
`ifdef SEG_BLINK_EN
            blank = phase && snap_blk[d];
`endif
            e.an  = en ? ~one : 8'hFF;
            e.seg = (!en || blank) ? 8'hFF : {~snap_pt[d], glyph(snap_num[4*d +: 4])};
            e.fd  = (k == 32);
            sb.push_back(e);
        end
        for (int k = 1; k <= 32; k++) begin
            if (k == chg_at + 1) begin
                in_num = nn; in_pt = np; in_blk = nb;
                drive();
            end
            @(negedge clk);
            got = sb.pop_front();
            chk({name, " AN"},  k, bus.AN,      got.an);
            chk({name, " SEG"}, k, bus.SEGMENT, got.seg);
            chk({name, " FD"},  k, {7'd0, bus.frame_done}, {7'd0, got.fd});
            if (k == abort_at) begin
                rst = 1'b1;
                #1;
                for (int r = 0; r < 3; r++) begin
                    chk({name, " RST AN"},  r, bus.AN,      8'hFF);
                    chk({name, " RST SEG"}, r, bus.SEGMENT, 8'hFF);
                    chk({name, " RST FD"},  r, {7'd0, bus.frame_done}, 8'h00);
                    @(negedge clk);
                end
                rst = 1'b0;
                sb.delete();
                snap_num = '0; snap_pt = '0; snap_blk = '0;
                phase = 1'b0;
                return;
            end
        end
        snap_num = in_num; snap_pt = in_pt; snap_blk = in_blk;
        phase = ~phase;
    endtask

    initial begin
        in_num = 32'h7654_3210; in_pt = 8'h00; in_blk = 8'h80;
        drive();
        bus.EN = 1'b1;
        snap_num = '0; snap_pt = '0; snap_blk = '0;
        phase = 1'b0;

        repeat (2) @(negedge clk);
        chk("RESET AN",  0, bus.AN,      8'hFF);
        chk("RESET SEG", 0, bus.SEGMENT, 8'hFF);
        chk("RESET FD",  0, {7'd0, bus.frame_done}, 8'h00);
        rst = 1'b0;

        frame("A_post_reset", 1'b1, 0,  32'h7654_3210, 8'h00, 8'h80, 0);
        frame("B_digits",     1'b1, 0,  32'h7654_3210, 8'h05, 8'h80, 0);
        frame("C_points",     1'b1, 0,  32'h0000_0000, 8'h00, 8'h80, 0);
        frame("D_midchange",  1'b1, 14, 32'hFFFF_FFFF, 8'h00, 8'h80, 0);
        frame("E_all_f",      1'b1, 0,  32'hFFFF_FFFF, 8'h00, 8'h80, 0);
        frame("F_en_off",     1'b0, 0,  32'hFFFF_FFFF, 8'h00, 8'h80, 0);
        frame("G_en_on",      1'b1, 0,  32'h7654_3210, 8'h00, 8'h80, 0);
        frame("H_abort",      1'b1, 0,  32'h7654_3210, 8'h00, 8'h80, 22);
        frame("I_after_rst",  1'b1, 0,  32'h7654_3210, 8'h00, 8'h80, 0);
        frame("J_resume",     1'b1, 0,  32'h7654_3210, 8'h00, 8'h80, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 Parameter SCAN_PERIOD, default 100000, clk cycles each digit stays selected (minimum 2).
REQ-002 Parameter BLINK_FRAMES, default 64, full scan frames per blink half-period (minimum 1).
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port EN  input  1  display enable; 0 blanks all digits.
REQ-006 Port Disp_num  input  32  eight hex nibbles; nibble i (bits 4i+3:4i) shown on digit i.
REQ-007 Port point_in  input  8  bit i=1 lights the decimal point of digit i.
REQ-008 Port blink_in  input  8  bit i=1 makes digit i blink.
REQ-009 Port AN  output  8  digit anodes, active-low, one-hot-low when displaying.
REQ-010 Port SEGMENT  output  8  segments, active-low; bits 6:0 = g..a, bit 7 = dp.
REQ-011 Port frame_done  output  1  one-cycle pulse when digit 7's slot ends.

Function
REQ-012 Prescale counter SHALL count 0..SCAN_PERIOD-1 and wrap to 0; the wrap edge is the "tick".
REQ-013 Digit index (3 bits) SHALL increment on every tick, wrapping 7->0.
REQ-014 frame_done SHALL be 1 for exactly the cycle after the tick where index goes 7->0.
REQ-015 Disp_num, point_in, blink_in SHALL be snapshotted only on the 7->0 tick, so one frame never mixes old and new data.
REQ-016 AN and SEGMENT SHALL be registered, reflecting the new index one cycle after the tick.
REQ-017 AN SHALL be ~(8'b1 << index) when EN=1, else 8'hFF.
REQ-018 SEGMENT[6:0] SHALL be the hex decode of the snapshot nibble (0-F, all 16 glyphs); SEGMENT[7] SHALL be ~point bit.
REQ-019 Blink phase SHALL toggle every BLINK_FRAMES frames; while phase=1 and blink bit of current digit=1, SEGMENT SHALL be 8'hFF (AN unchanged).
REQ-020 EN=0 SHALL not stop the prescale, index, blink or snapshot logic; only the outputs blank.
REQ-021 Input changes mid-frame SHALL have no visible effect until the next frame boundary.

Reset
REQ-022 rst=1 SHALL immediately force AN=8'hFF, SEGMENT=8'hFF, frame_done=0, prescale=0, index=0, blink phase=0, frame counter=0, snapshots=0.
REQ-023 After rst deassert, the first tick SHALL occur SCAN_PERIOD cycles later and select digit 1; digit 0 shows the zero snapshot until the first frame boundary.
REQ-024 Reset asserted mid-frame SHALL abandon the frame; no frame_done pulse is produced for it.

Configuration
REQ-025 Macro SEG_BLINK_EN defined: blink phase counter and REQ-019 are compiled in.
REQ-026 Macro SEG_BLINK_EN undefined: blink logic is absent; blink_in is ignored and digits never blank for blinking; all other behaviour is identical.

Structure
REQ-027 Package seg7_pkg SHALL hold the digit count (8), the 16-entry active-low hex-to-segment table, and the blank constant 8'hFF.
REQ-028 Sub-module seg7_hex_decode (4-bit nibble in, 7-bit active-low segments out, combinational) SHALL be instantiated once.

Verification
REQ-029 SCAN_PERIOD=4, EN=1, Disp_num=32'h76543210, point_in=0, after the first frame boundary -> AN steps FE,FD,...,7F every 4 cycles; SEGMENT[6:0] shows 0..7 glyphs; SEGMENT[7]=1.
REQ-030 point_in=8'h05 -> SEGMENT[7]=0 only while AN=FE or FB.
REQ-031 SEG_BLINK_EN, BLINK_FRAMES=1, blink_in=8'h80 -> digit 7 SEGMENT=FF on alternate frames; other digits unaffected; without macro digit 7 is never blanked.
REQ-032 Disp_num changed 32'h0->32'hFFFFFFFF while index=3 -> digits 4-7 still show 0 this frame; all show F next frame.
REQ-033 EN=0 for a full frame -> AN=FF throughout, frame_done still pulses every 32 cycles; EN=1 resumes at the correct current index.
REQ-034 rst pulsed while index=5 -> AN=SEGMENT=FF immediately, no frame_done; after release first AN=FD appears 5 cycles later (tick + 1 register cycle).
